// File: rtl/match_event_logger.sv
// Counts and timestamps detector match pulses and buffers the timestamps in a
// first-word-fall-through FIFO that a host drains through a pin-driven pop strobe.
module match_event_logger #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match_i,
  input  logic             clr_i,
  input  logic             pop_pin,
  output logic [TS_W-1:0]  rd_data,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic pop_pulse_c;
  logic do_pop_c;
  logic do_push_c;
  logic empty_c;
  logic full_c;

  // Pointer-derived status; the extra MSB distinguishes full from empty
  always_comb begin
    empty_c = (wptr_q == rptr_q);
    full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  end

  // Rising edge of the synchronized host strobe
  always_comb begin
    pop_pulse_c = sync2_q & ~sync3_q;
  end

  // Push/pop arbitration; a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    do_pop_c  = pop_pulse_c & ~empty_c & ~clr_i;
    do_push_c = match_i & (~full_c | do_pop_c) & ~clr_i;

    ts_d   = ts_q + TS_W'(1);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (clr_i) begin
      ts_d   = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (do_push_c) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (do_pop_c) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (match_i && !do_push_c) begin
        ovf_d = 1'b1;
      end
      if (match_i && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Two-flop synchronizer plus edge-detect flop; deliberately untouched by clr_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pop_pin;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Storage is not reset; stale contents are masked by empty
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wptr_q[AW-1:0]] <= ts_q;
    end
  end

  always_comb begin
    rd_data   = empty_c ? '0 : mem_q[rptr_q[AW-1:0]];
    empty     = empty_c;
    full      = full_c;
    ovf       = ovf_q;
    match_cnt = cnt_q;
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed bench for match_event_logger, checked every cycle
// against a queue-based reference model.
module tb_match_event_logger;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             match_i;
  logic             clr_i;
  logic             pop_pin;
  logic [TS_W-1:0]  rd_data;
  logic             empty;
  logic             full;
  logic             ovf;
  logic [CNT_W-1:0] match_cnt;

  int ntests;
  int nfail;

  // Reference model state
  int          m_ts;
  logic [7:0]  m_q[$];
  int          m_cnt;
  bit          m_ovf;
  bit          m_prev_pin;
  int          m_edge;
  int          m_pop_at[$];

  match_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .match_i   (match_i),
    .clr_i     (clr_i),
    .pop_pin   (pop_pin),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ts = 0;
    m_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_prev_pin = 1'b0;
    m_pop_at.delete();
  endtask

  // One clock edge of the reference behaviour; a pin rise first seen at edge R pops at R+2
  task automatic model_edge(input bit m, input bit c, input bit p);
    bit pop_now;
    m_edge++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (p && !m_prev_pin) m_pop_at.push_back(m_edge + 2);
    m_prev_pin = p;
    pop_now = 1'b0;
    if (m_pop_at.size() > 0 && m_pop_at[0] == m_edge) begin
      void'(m_pop_at.pop_front());
      pop_now = 1'b1;
    end
    if (c) begin
      m_ts = 0;
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      return;
    end
    if (pop_now && m_q.size() > 0) begin
      if (m && m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_q.push_back(8'(m_ts));
        m = 1'b0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        void'(m_q.pop_front());
      end
    end
    if (m) begin
      if (m_cnt < 255) m_cnt++;
      if (m_q.size() < DEPTH) m_q.push_back(8'(m_ts));
      else m_ovf = 1'b1;
    end
    m_ts = (m_ts + 1) % 256;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_rd;
    exp_rd = (m_q.size() > 0) ? m_q[0] : 8'd0;
    chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(m_cnt));
    chk({tag, ".rd"}, 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic cycle(input string tag, input bit m, input bit c, input bit p);
    match_i = m;
    clr_i   = c;
    pop_pin = p;
    @(posedge clk);
    model_edge(m, c, p);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".ovf"}, 32'(ovf), 32'd0);
    chk({tag, ".cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, ".rd"}, 32'(rd_data), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("rst_async");
    repeat (2) cycle("in_rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    ntests = 0;
    nfail = 0;
    m_edge = 0;
    match_i = 1'b0;
    clr_i = 1'b0;
    pop_pin = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #2;

    // Reset then idle
    do_reset();
    repeat (10) cycle("idle", 1'b0, 1'b0, 1'b0);
    check_reset_vals("idle_end");

    // Matches at ts=3 and ts=7, then two single pops
    do_reset();
    for (int i = 0; i < 10; i++) cycle("ts37", (m_ts == 3) || (m_ts == 7), 1'b0, 1'b0);
    chk("ts37.cnt2", 32'(match_cnt), 32'd2);
    chk("ts37.head3", 32'(rd_data), 32'd3);
    cycle("pop1", 1'b0, 1'b0, 1'b1);
    repeat (3) cycle("pop1", 1'b0, 1'b0, 1'b0);
    chk("pop1.head7", 32'(rd_data), 32'd7);
    cycle("pop2", 1'b0, 1'b0, 1'b1);
    repeat (3) cycle("pop2", 1'b0, 1'b0, 1'b0);
    chk("pop2.empty", 32'(empty), 32'd1);
    chk("pop2.rd0", 32'(rd_data), 32'd0);

    // Five matches into a four-deep FIFO, then drain
    cycle("ovf_clr", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("fill", 1'b1, 1'b0, 1'b0);
      if (i == 3) chk("fill.full4", 32'(full), 32'd1);
    end
    chk("fill.ovf", 32'(ovf), 32'd1);
    chk("fill.cnt5", 32'(match_cnt), 32'd5);
    for (int i = 0; i < 4; i++) begin
      cycle("drain", 1'b0, 1'b0, 1'b1);
      repeat (2) cycle("drain", 1'b0, 1'b0, 1'b0);
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // Full FIFO: push coincides with pop_pulse
    cycle("fp_clr", 1'b0, 1'b1, 1'b0);
    repeat (4) cycle("fp_fill", 1'b1, 1'b0, 1'b0);
    cycle("fp_rise", 1'b0, 1'b0, 1'b1);
    cycle("fp_wait", 1'b0, 1'b0, 1'b0);
    cycle("fp_both", 1'b1, 1'b0, 1'b0);
    chk("fp.full", 32'(full), 32'd1);
    chk("fp.ovf", 32'(ovf), 32'd0);

    // Saturation with a steady drain
    cycle("sat_clr", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 1'b0, (i % 3) == 0);
    chk("sat.cnt255", 32'(match_cnt), 32'd255);

    // Timestamp wrap: match taken 260 cycles after clear reads 4
    cycle("wrap_clr", 1'b0, 1'b1, 1'b0);
    repeat (260) cycle("wrap", 1'b0, 1'b0, 1'b0);
    cycle("wrap_m", 1'b1, 1'b0, 1'b0);
    chk("wrap.ts4", 32'(rd_data), 32'd4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 35));
    end

    // Clear together with a match while three entries are held
    cycle("mid_clr0", 1'b0, 1'b1, 1'b0);
    repeat (3) cycle("mid_fill", 1'b1, 1'b0, 1'b0);
    cycle("mid_clr", 1'b1, 1'b1, 1'b0);
    chk("mid_clr.empty", 32'(empty), 32'd1);
    chk("mid_clr.cnt", 32'(match_cnt), 32'd0);
    cycle("mid_after", 1'b1, 1'b0, 1'b0);
    chk("mid_after.ts0", 32'(rd_data), 32'd0);

    // Reset asserted while a pop is in flight
    cycle("rp_fill", 1'b1, 1'b0, 1'b0);
    cycle("rp_rise", 1'b0, 1'b0, 1'b1);
    do_reset();
    repeat (5) cycle("post_rst", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial "101" Mealy detector's one-cycle match pulse. It counts matches, timestamps each one against a free-running cycle counter and buffers the timestamps in a small first-word-fall-through FIFO. A slow external host drains the FIFO through a pin-driven pop strobe. It sits between the detector output and the chip output pins.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TS_W, 8: timestamp counter and FIFO entry width.
- CNT_W, 8: match counter width.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- match_i  in  1  detector match pulse; same clock domain; sampled every rising edge
- clr_i  in  1  synchronous clear; same clock domain; level-sensitive
- pop_pin  in  1  host read strobe; asynchronous to clk; one pop per rising edge
- rd_data  out  TS_W  timestamp at FIFO head; 0 when empty
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds DEPTH entries
- ovf  out  1  sticky; set when a match is dropped
- match_cnt  out  CNT_W  total matches since reset or clear; saturating

## Operation
- Timestamp counter `ts`:
  - Free-running; increments every cycle.
  - Wraps from 2^TS_W-1 to 0.
  - Zeroed by reset or clr_i.
- Push:
  - When match_i=1 at an edge, the current `ts` value (the value before that edge's increment) is written at the tail.
  - Tail pointer advances on the same edge.
- Pop path:
  - pop_pin passes through a 2-flop synchronizer.
  - A third flop detects the rising edge; pop_pulse = s2 & ~s3.
  - Each pop_pulse advances the head by one.
- Storage: DEPTH x TS_W register array.
- Pointers: log2(DEPTH)+1 bits, with the extra bit used for wrap.
  - empty = (wptr == rptr).
  - full = pointer MSBs differ and the index bits are equal.
- rd_data = mem[rptr index] when !empty, else 0. It is combinational from registers (first-word fall-through).
- match_cnt:
  - Increments on every match_i=1, including dropped ones.
  - Saturates at 2^CNT_W-1.
- Boundary rules:
  - Push while full with no pop in the same cycle: entry dropped, ovf <= 1, pointers unchanged.
  - Push and pop_pulse in the same cycle while full: both performed, occupancy unchanged, ovf not set.
  - Push and pop_pulse in the same cycle while empty: push only; the pop is ignored.
  - pop_pulse while empty: ignored, no pointer movement.
  - Push and pop in the same cycle while neither full nor empty: both performed.
- Clear:
  - clr_i=1 zeroes ts, both pointers, match_cnt and ovf at the next edge.
  - clr_i overrides any push or pop in that cycle.
  - Synchronizer flops are not cleared.
- Reset (async assert, takes effect immediately):
  - ts, pointers, match_cnt, ovf and synchronizer flops = 0.
  - Outputs: empty=1, full=0, ovf=0, match_cnt=0, rd_data=0.
  - Memory contents need not be reset; they are masked by empty.

## Timing
- match_i high at edge N: entry is visible on rd_data, with empty=0, after edge N, provided the FIFO was empty. match_cnt updates after edge N.
- pop_pin rise between edges: pop_pulse is high during the cycle after the second synchronizer edge. The head advances on the third edge after the rise, with 2-3 cycles of uncertainty.
- pop_pin held high: exactly one pop; the next pop requires a low of at least 2 clk cycles.
- All outputs are glitch-free register-derived values, except rd_data, which is a registered-select mux.

## Test plan
- Reset then idle 10 cycles → empty=1, full=0, ovf=0, match_cnt=0, rd_data=0.
- After reset, match_i pulses at ts=3 and ts=7 → match_cnt=2; rd_data=3. Pulse pop_pin once → rd_data=7 within 3 cycles. Pulse again → empty=1, rd_data=0.
- Five matches with DEPTH=4 and no pops → full=1 after the 4th; the 5th is dropped; ovf=1, match_cnt=5. Draining returns the first four timestamps in order, then empty=1.
- With FIFO full, assert match_i in the same cycle as pop_pulse → occupancy stays 4, ovf=0, and the newest timestamp lands at the tail.
- 300 matches with continuous drain → match_cnt saturates at 255. A timestamp taken after 256 cycles wraps; for example, a match at cycle 260 reads 4.
- Mid-operation: with 3 entries, assert clr_i together with match_i → next cycle empty=1, match_cnt=0, ovf=0, ts restarts at 0. Assert rst_n low mid-pop → all outputs at reset values immediately.
